// File: rtl/sequential_subtractor.sv
// Bit-serial subtractor: D = A_in - B_in - Bor_in, one bit per clock, LSB first.
// Define SEQUENTIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output OVF.
module sequential_subtractor #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             Bor_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bor_out
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   d_sh_q, d_sh_d;
    logic               bor_q, bor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bor_out_q, bor_out_d;
    logic               done_q, done_d;
    logic               d_bit;
    logic               bor_nxt;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs.
    assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
    assign bor_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~a_sh_q[0] & bor_q) | (b_sh_q[0] & bor_q);

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        d_sh_d    = d_sh_q;
        bor_d     = bor_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        bor_out_d = bor_out_q;
        done_d    = 1'b0;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    a_sh_d  = A_in;
                    b_sh_d  = B_in;
                    bor_d   = Bor_in;
                    d_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                d_sh_d            = d_sh_q >> 1;
                d_sh_d[WIDTH-1]   = d_bit;
                bor_d             = bor_nxt;
                cnt_d             = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Outputs update only here, so D never shows partial values.
                    d_d       = d_sh_d;
                    bor_out_d = bor_nxt;
                    done_d    = 1'b1;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
                    ovf_d     = bor_q ^ bor_nxt;
`endif
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            d_sh_q    <= '0;
            bor_q     <= 1'b0;
            cnt_q     <= '0;
            d_q       <= '0;
            bor_out_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            d_sh_q    <= d_sh_d;
            bor_q     <= bor_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            bor_out_q <= bor_out_d;
            done_q    <= done_d;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign done    = done_q;
    assign D       = d_q;
    assign Bor_out = bor_out_q;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
    assign OVF     = ovf_q;
`endif

endmodule

// File: tb/tb_sequential_subtractor.sv
// Directed bench for sequential_subtractor (WIDTH=3): latency, arithmetic, reset, input stability.
`timescale 1ns/1ps
module tb_sequential_subtractor;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             Bor_in;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bor_out;
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
    logic             OVF;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sequential_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .Bor_in  (Bor_in),
        .A_in    (A_in),
        .B_in    (B_in),
        .done    (done),
        .D       (D),
        .Bor_out (Bor_out)
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
        ,
        .OVF     (OVF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Start one operation, then check done timing and the result.
    task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b,
                          input logic bi, input logic [2:0] exp_d, input logic exp_bo);
        @(negedge clk);
        A_in = a; B_in = b; Bor_in = bi; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check({tag, "_done_early"}, {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_res"}, {28'd0, Bor_out, D}, {28'd0, exp_bo, exp_d});
        @(posedge clk); #1;
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int exp_v;
        rst = 1'b1; en = 1'b0; Bor_in = 1'b0; A_in = '0; B_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {28'd0, done, Bor_out, D}, 32'd0);
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
        check("reset_ovf", {31'd0, OVF}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("a5_b1", 3'd5, 3'd1, 1'b0, 3'd4, 1'b0);
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
        check("ovf_a5_b1", {31'd0, OVF}, 32'd0);
`endif
        run_op("a2_b5", 3'd2, 3'd5, 1'b0, 3'd5, 1'b1);
        run_op("a0_b0_bi", 3'd0, 3'd0, 1'b1, 3'd7, 1'b1);
        run_op("a7_b7_bi", 3'd7, 3'd7, 1'b1, 3'd7, 1'b1);
`ifdef SEQUENTIAL_SUBTRACTOR_OVF_EN
        run_op("a3_b4", 3'd3, 3'd4, 1'b0, 3'd7, 1'b1);
        check("ovf_a3_b4", {31'd0, OVF}, 32'd1);
`endif

        // Back-to-back with en held high: one result every 5 cycles.
        for (int k = 0; k < 128; k++) begin
            int a, b, bi;
            a  = k % 8;
            b  = (k / 8) % 8;
            bi = k / 64;
            @(negedge clk);
            A_in = 3'(a); B_in = 3'(b); Bor_in = 1'(bi); en = 1'b1;
            @(posedge clk);
            repeat (3) @(posedge clk);
            #1;
            exp_v = (a - b - bi) & 15;
            check($sformatf("exh_%0d_%0d_%0d", a, b, bi), {27'd0, done, Bor_out, D},
                  {27'd0, 1'b1, 4'(exp_v)});
            @(posedge clk); #1;
            check($sformatf("exh_%0d_%0d_%0d_low", a, b, bi), {31'd0, done}, 32'd0);
            if (k == 127) begin
                @(negedge clk);
                en = 1'b0;
            end
        end

        // Reset during CALC discards the partial result.
        @(negedge clk);
        A_in = 3'd6; B_in = 3'd1; Bor_in = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_outs", {28'd0, done, Bor_out, D}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", {28'd0, done, Bor_out, D}, 32'd0);
        end
        run_op("after_rst", 3'd6, 3'd1, 1'b0, 3'd5, 1'b0);

        // Operands and en changing mid-operation are ignored.
        @(negedge clk);
        A_in = 3'd6; B_in = 3'd2; Bor_in = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        A_in = 3'd0; B_in = 3'd0;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        check("stable_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("stable_res", {28'd0, done, Bor_out, D}, {28'd0, 1'b1, 1'b0, 3'd4});
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("stable_no_done", {31'd0, done}, 32'd0);
        end
        check("stable_hold", {28'd0, Bor_out, D}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
